// File: rtl/note_tone_gen.sv
// ----------------------------------------------------------------------------
// note_tone_gen
//
// Turns a semitone index from the music ROM into a square wave on `speaker`.
// A new note is decomposed into octave/semitone by repeated subtraction of 12.
// Each subtraction takes one DIV cycle, and a single LOAD cycle then latches
// the half-period. PLAY toggles the speaker every `half` cycles.
//
// Ports
//   clk           in   1  system clock, all logic on its rising edge
//   reset         in   1  synchronous, active-high reset
//   note          in   8  semitone index, 0 = rest
//   enable        in   1  play enable, 0 = mute
//   speaker       out  1  registered square-wave output
//   busy          out  1  high while a note is being decoded (DIV or LOAD)
//   playing       out  1  high in PLAY
//   out_of_range  out  1  registered, high when the held note's octave > 7
// ----------------------------------------------------------------------------
module note_tone_gen #(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] note,
    input  logic       enable,
    output logic       speaker,
    output logic       busy,
    output logic       playing,
    output logic       out_of_range
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_LOAD = 2'd2,
        ST_PLAY = 2'd3
    } state_e;

    // Octave-0 half-period in clock cycles for semitone k (C = 0 .. B = 11).
    // A0 (k = 9) is 27.5 Hz. The ratio is 2^((k-9)/12), listed explicitly so
    // the table needs only basic real arithmetic at elaboration time.
    function automatic logic [21:0] base_period(input int k);
        real ratio;
        case (k)
            0:       ratio = 0.5946035575013605;
            1:       ratio = 0.6299605249474366;
            2:       ratio = 0.6674199270850172;
            3:       ratio = 0.7071067811865476;
            4:       ratio = 0.7491535384383408;
            5:       ratio = 0.7937005259840998;
            6:       ratio = 0.8408964152537145;
            7:       ratio = 0.8908987181403393;
            8:       ratio = 0.9438743126816935;
            9:       ratio = 1.0;
            10:      ratio = 1.0594630943592953;
            11:      ratio = 1.1224620483093730;
            default: ratio = 0.0;
        endcase
        if (ratio == 0.0)
            return 22'd0;
        return 22'($rtoi(real'(CLK_HZ) / (55.0 * ratio) + 0.5));
    endfunction

    // Padded to 16 entries so the 4-bit remainder indexes it directly.
    // Entries 12..15 are unreachable because LOAD always sees rem < 12.
    localparam logic [21:0] BASE_TABLE [0:15] = '{
        base_period(0),  base_period(1),  base_period(2),  base_period(3),
        base_period(4),  base_period(5),  base_period(6),  base_period(7),
        base_period(8),  base_period(9),  base_period(10), base_period(11),
        22'd0,           22'd0,           22'd0,           22'd0
    };

    state_e      state_q,    state_d;
    logic [7:0]  cur_note_q, cur_note_d;
    logic [7:0]  rem_q,      rem_d;
    logic [4:0]  oct_q,      oct_d;       // up to 21 for note 255
    logic [21:0] counter_q,  counter_d;
    logic [21:0] half_q,     half_d;
    logic        speaker_q,  speaker_d;
    logic        oor_q,      oor_d;

    logic [21:0] base_sel;
    logic [21:0] half_m1;
    logic        octave_high;

    assign base_sel    = BASE_TABLE[rem_q[3:0]];
    assign half_m1     = half_q - 22'd1;
    assign octave_high = (oct_q > 5'd7);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_note_q <= '0;
            rem_q      <= '0;
            oct_q      <= '0;
            counter_q  <= '0;
            half_q     <= '0;
            speaker_q  <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_note_q <= cur_note_d;
            rem_q      <= rem_d;
            oct_q      <= oct_d;
            counter_q  <= counter_d;
            half_q     <= half_d;
            speaker_q  <= speaker_d;
            oor_q      <= oor_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // Priority: mute > retrigger on a note change > normal state behaviour.
    // A retrigger in DIV/LOAD abandons the decode before LOAD can write
    // half, so a stale half-period never reaches PLAY.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this
        // block leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        cur_note_d = cur_note_q;
        rem_d      = rem_q;
        oct_d      = oct_q;
        counter_d  = counter_q;
        half_d     = half_q;
        speaker_d  = speaker_q;
        oor_d      = oor_q;

        if (!enable) begin
            // Clearing cur_note makes the next enable with a nonzero note
            // a full retrigger. out_of_range keeps its last value.
            state_d    = ST_IDLE;
            cur_note_d = '0;
            counter_d  = '0;
            speaker_d  = 1'b0;
        end else if (note != cur_note_q) begin
            state_d    = ST_DIV;
            cur_note_d = note;
            rem_d      = note;
            oct_d      = '0;
            counter_d  = '0;
            speaker_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    counter_d = '0;
                    speaker_d = 1'b0;
                end
                ST_DIV: begin
                    if (rem_q >= 8'd12) begin
                        rem_d = rem_q - 8'd12;
                        oct_d = oct_q + 5'd1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    half_d  = base_sel >> oct_q;
                    oor_d   = octave_high;
                    state_d = ((cur_note_q == 8'd0) || octave_high) ? ST_IDLE : ST_PLAY;
                end
                ST_PLAY: begin
                    // Toggling when counter reaches half-1 places the first
                    // rising edge exactly `half` cycles after PLAY entry.
                    if (counter_q == half_m1) begin
                        counter_d = '0;
                        speaker_d = ~speaker_q;
                    end else begin
                        counter_d = counter_q + 22'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (state_q == ST_DIV) || (state_q == ST_LOAD);
        playing = (state_q == ST_PLAY);
    end

    assign speaker      = speaker_q;
    assign out_of_range = oor_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// ----------------------------------------------------------------------------
// tb_note_tone_gen
//
// Two instances share the same inputs:
//   dut    default 100 MHz clock; its half-period register is compared with
//          hand-computed table values.
//   dut_s  CLK_HZ = 5500, so base[A] = 100 cycles. This keeps whole speaker
//          periods short enough to measure (note 33 -> half 25, note 45 -> 12).
// ----------------------------------------------------------------------------
module tb_note_tone_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] note;
    logic       enable;

    logic speaker,   busy,   playing,   oor;
    logic speaker_s, busy_s, playing_s, oor_s;

    int checks   = 0;
    int failures = 0;

    note_tone_gen dut (
        .clk          (clk),
        .reset        (reset),
        .note         (note),
        .enable       (enable),
        .speaker      (speaker),
        .busy         (busy),
        .playing      (playing),
        .out_of_range (oor)
    );

    note_tone_gen #(.CLK_HZ(5500)) dut_s (
        .clk          (clk),
        .reset        (reset),
        .note         (note),
        .enable       (enable),
        .speaker      (speaker_s),
        .busy         (busy_s),
        .playing      (playing_s),
        .out_of_range (oor_s)
    );

    always #5 clk = ~clk;

    initial begin
        #300us;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        note   = 8'd0;
        tick();
        reset  = 1'b0;
    endtask

    // Count consecutive busy cycles, starting with the current sample.
    task automatic wait_decode(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    // Count cycles until dut_s.speaker reaches lvl, with a bounded budget.
    task automatic count_to(input logic lvl, output int k);
        k = 0;
        while (speaker_s !== lvl && k < 200) begin
            tick();
            k++;
        end
    endtask

    typedef struct {
        logic [7:0]  note;
        int          busy_cycles;   // DIV cycles (note/12 + 1) plus one LOAD cycle
        logic [21:0] half;          // dut half-period at 100 MHz
        logic        oor;
        logic        playing;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int n;
        int k;
        logic seen_high;

        // A rest after reset does not differ from cur_note, so nothing decodes.
        vecs[0] = '{8'd0,   0,  22'd0,       1'b0, 1'b0};
        vecs[1] = '{8'd9,   2,  22'd1818182, 1'b0, 1'b1};  // A0
        vecs[2] = '{8'd33,  4,  22'd454545,  1'b0, 1'b1};  // A2
        vecs[3] = '{8'd45,  5,  22'd227272,  1'b0, 1'b1};  // A3
        vecs[4] = '{8'd48,  6,  22'd191112,  1'b0, 1'b1};  // C4
        vecs[5] = '{8'd95,  9,  22'd12654,   1'b0, 1'b1};  // B7, highest legal octave
        vecs[6] = '{8'd96,  10, 22'd11944,   1'b1, 1'b0};  // C8, first out-of-range
        vecs[7] = '{8'd100, 10, 22'd9480,    1'b1, 1'b0};  // E8
        vecs[8] = '{8'd255, 23, 22'd1,       1'b1, 1'b0};  // longest decode

        reset  = 1'b1;
        enable = 1'b0;
        note   = 8'd0;
        tick();

        // Decode table
        foreach (vecs[i]) begin
            do_reset();
            note   = vecs[i].note;
            enable = 1'b1;
            tick();
            wait_decode(n);
            check($sformatf("busy_cycles[%0d]", vecs[i].note), n, vecs[i].busy_cycles);
            check($sformatf("half[%0d]", vecs[i].note), 32'(dut.half_q), 32'(vecs[i].half));
            check($sformatf("oor[%0d]", vecs[i].note), oor, vecs[i].oor);
            check($sformatf("oor_s[%0d]", vecs[i].note), oor_s, vecs[i].oor);
            check($sformatf("playing[%0d]", vecs[i].note), playing, vecs[i].playing);
            check($sformatf("playing_s[%0d]", vecs[i].note), playing_s, vecs[i].playing);
            check($sformatf("busy_s_done[%0d]", vecs[i].note), busy_s, 0);
            check($sformatf("speaker_after_load[%0d]", vecs[i].note), speaker, 0);
        end

        // Reset overrides enable and a pending trigger
        reset  = 1'b1;
        enable = 1'b1;
        note   = 8'd33;
        tick();
        check("rst_busy", busy, 0);
        check("rst_playing", playing, 0);
        check("rst_speaker", speaker_s, 0);
        check("rst_oor", oor, 0);
        check("rst_half", 32'(dut.half_q), 0);

        // Released with enable=1 and note 33: retrigger, then a 50% duty wave
        reset = 1'b0;
        tick();
        check("post_rst_retrigger_busy", busy, 1);
        wait_decode(n);
        check("n33_busy_cycles", n, 4);
        check("n33_half", 32'(dut.half_q), 454545);
        count_to(1'b1, k);
        check("n33_first_rise", k, 25);
        count_to(1'b0, k);
        check("n33_high_time", k, 25);
        check("n33_dut_speaker_low", speaker, 0);
        count_to(1'b1, k);
        check("n33_low_time", k, 25);

        // 33 -> 45 while the speaker is high: forced low at the change edge
        note = 8'd45;
        tick();
        check("chg_speaker_forced_low", speaker_s, 0);
        check("chg_busy", busy, 1);
        wait_decode(n);
        check("n45_busy_cycles", n, 5);
        check("n45_half", 32'(dut.half_q), 227272);
        count_to(1'b1, k);
        check("n45_first_rise", k, 12);
        count_to(1'b0, k);
        check("n45_high_time", k, 12);

        // Mid-PLAY mute, then unmute with the same note: full retrigger
        count_to(1'b1, k);
        enable = 1'b0;
        tick();
        check("mute_speaker", speaker_s, 0);
        check("mute_playing", playing, 0);
        check("mute_busy", busy, 0);
        tick();
        tick();
        enable = 1'b1;
        tick();
        check("unmute_retrigger_busy", busy, 1);
        wait_decode(n);
        check("unmute_busy_cycles", n, 5);
        count_to(1'b1, k);
        check("unmute_first_rise", k, 12);

        // Rest while playing: one DIV, one LOAD, then IDLE and silent
        note = 8'd0;
        tick();
        check("rest_busy", busy, 1);
        wait_decode(n);
        check("rest_busy_cycles", n, 2);
        check("rest_playing", playing, 0);
        seen_high = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (speaker_s !== 1'b0) seen_high = 1'b1;
            tick();
        end
        check("rest_silent", seen_high, 0);

        // Octave 8 raises out_of_range, which holds until the next LOAD
        note = 8'd100;
        tick();
        wait_decode(n);
        check("n100_oor", oor, 1);
        check("n100_playing", playing, 0);
        check("n100_speaker", speaker_s, 0);
        note = 8'd33;
        tick();
        check("n33_oor_held_in_div", oor, 1);
        wait_decode(n);
        check("n33_oor_cleared", oor, 0);
        check("n33_playing_again", playing, 1);

        // Note changes every 3 cycles keep the decoder busy and silent
        foreach (vecs[i]) begin
            if (i < 5) begin
                seen_high = 1'b0;
                note = 8'd120 + 8'(i * 23);
                for (int c = 0; c < 3; c++) begin
                    tick();
                    if (busy !== 1'b1 || speaker_s !== 1'b0) seen_high = 1'b1;
                end
                check($sformatf("churn_busy_silent[%0d]", i), seen_high, 0);
            end
        end
        note = 8'd45;
        tick();
        wait_decode(n);
        check("churn_settle_busy_cycles", n, 5);
        check("churn_settle_half", 32'(dut.half_q), 227272);
        count_to(1'b1, k);
        check("churn_settle_first_rise", k, 12);

        // Enable rising with note 0 leaves the block idle
        enable = 1'b0;
        note   = 8'd0;
        tick();
        tick();
        enable = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check("en_rest_busy", busy, 0);
        check("en_rest_playing", playing, 0);
        check("en_rest_speaker", speaker_s, 0);

        // out_of_range holds across a mute
        note = 8'd100;
        tick();
        wait_decode(n);
        enable = 1'b0;
        tick();
        check("mute_oor_held", oor, 1);

        // Reset mid-DIV clears everything on that edge
        enable = 1'b1;
        note   = 8'd200;
        tick();
        tick();
        tick();
        check("mid_div_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("mid_div_rst_busy", busy, 0);
        check("mid_div_rst_playing", playing, 0);
        check("mid_div_rst_speaker", speaker_s, 0);
        check("mid_div_rst_oor", oor, 0);
        check("mid_div_rst_half", 32'(dut.half_q), 0);
        reset = 1'b0;
        tick();
        check("post_rst_note200_busy", busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
